// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch queue between Fetch
// and the memory controller's instruction port. Keeps up to DEPTH
// {address, instruction} pairs, serves Fetch from the head, and flushes and
// restarts from the new PC on any redirect.
//
// Optional build macro: PF_STATS_EN adds saturating hit/miss counters
// (pf_hit_count, pf_miss_count).
//
// Handshake: pf_mc_en is a level request. Once raised, it stays high with a
// stable pf_mc_addr until the one-cycle mc_pf_ack pulse, which marks
// mc_pf_data valid. Only one request is ever outstanding. On the Fetch side
// there is no ready: pf_if_valid is combinational, and a served entry is
// consumed in the same cycle unless ex_if_stall is high.
module instr_prefetch_buffer #(
  parameter int                 DEPTH      = 4,
  parameter int                 ADDR_W     = 18,
  parameter int                 ADDR_STEP  = 2,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_pf_req,
  input  logic [ADDR_W-1:0] if_pf_addr,
  input  logic              ex_if_stall,
  output logic              pf_if_valid,
  output logic [31:0]       pf_if_instruc,
  output logic              pf_mc_en,
  output logic [ADDR_W-1:0] pf_mc_addr,
  input  logic              mc_pf_ack,
  input  logic [31:0]       mc_pf_data
`ifdef PF_STATS_EN
  ,
  output logic [15:0]       pf_hit_count,
  output logic [15:0]       pf_miss_count
`endif
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // IDLE: no read in flight. BUSY: read in flight, data will be kept.
  // DRAIN: read in flight, but its data belongs to a flushed stream.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [ADDR_W-1:0] mc_addr_q;

  logic              empty, full;
  logic [ADDR_W-1:0] head_addr, expected_addr;
  logic              redirect, pop, push, issue;

  assign empty         = (count_q == '0);
  assign full          = (count_q == DEPTH_C);
  assign head_addr     = addr_mem[head_q];
  // The PC Fetch should ask for next: the queue head, or the address that
  // will arrive next when nothing is buffered yet.
  assign expected_addr = empty ? fetch_addr_q : head_addr;
  assign redirect      = if_pf_req && (if_pf_addr != expected_addr);

  assign pf_if_valid   = if_pf_req && !empty && (head_addr == if_pf_addr);
  assign pf_if_instruc = empty ? 32'd0 : data_mem[head_q];
  assign pop           = pf_if_valid && !ex_if_stall;
  // A flush in the ack cycle discards the returning data.
  assign push          = (state_q == BUSY) && mc_pf_ack && !redirect;

  assign pf_mc_en      = (state_q != IDLE);
  assign pf_mc_addr    = mc_addr_q;

  // Request FSM next-state: issue when there is room, track the in-flight read.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && !full) begin
          state_d = BUSY;
          issue   = 1'b1;
        end
      end
      BUSY: begin
        if (mc_pf_ack)     state_d = IDLE;
        else if (redirect) state_d = DRAIN;
      end
      DRAIN: begin
        if (mc_pf_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request FSM state register and latched request address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mc_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) mc_addr_q <= fetch_addr_q;
    end
  end

  // Next sequential fetch address; a redirect reloads it with the new PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_addr_q <= RESET_ADDR;
    end else if (redirect) begin
      fetch_addr_q <= if_pf_addr;
    end else if (push) begin
      fetch_addr_q <= fetch_addr_q + ADDR_W'(ADDR_STEP);
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_ONE;
      if (pop)  head_q <= head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are only meaningful between head and tail.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= fetch_addr_q;
      data_mem[tail_q] <= mc_pf_data;
    end
  end

`ifdef PF_STATS_EN
  // Saturating hit (pop) and miss (redirect) counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pf_hit_count  <= '0;
      pf_miss_count <= '0;
    end else begin
      if (pop && (pf_hit_count != 16'hFFFF))       pf_hit_count  <= pf_hit_count + 16'd1;
      if (redirect && (pf_miss_count != 16'hFFFF)) pf_miss_count <= pf_miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Instruction prefetch queue between the Fetch stage and the memory controller's instruction port.
- Issues sequential 32-bit instruction reads ahead of the PC and holds up to DEPTH {address, instruction} pairs.
- Serves Fetch from the queue head; flushes and restarts on any PC redirect (branch/jump).
- One clock; all state is clocked on clock.

Parameters:
DEPTH, 4, queue entries (power of two, 2..16)
ADDR_W, 18, instruction address width (memory-controller address space)
ADDR_STEP, 2, address increment per 32-bit instruction (two 16-bit RAM words)
RESET_ADDR, 0, first address prefetched after reset

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
if_pf_req  input  1  Fetch wants the instruction at if_pf_addr this cycle
if_pf_addr  input  ADDR_W  current PC from Fetch
ex_if_stall  input  1  pipeline stall; a served instruction is not consumed
pf_if_valid  output  1  pf_if_instruc is the instruction for if_pf_addr
pf_if_instruc  output  32  queue-head instruction
pf_mc_en  output  1  read request to the memory controller
pf_mc_addr  output  ADDR_W  request address
mc_pf_ack  input  1  one-cycle pulse: read done, mc_pf_data valid
mc_pf_data  input  32  read data

Behaviour:
- Reset (async, active-high): queue empty, count=0, state IDLE, fetch_addr=RESET_ADDR. Outputs pf_mc_en=0, pf_mc_addr=0, pf_if_valid=0, pf_if_instruc=0.
- State machine: IDLE, BUSY, DRAIN.
  - IDLE: if count<DEPTH, assert pf_mc_en with pf_mc_addr=fetch_addr; go to BUSY (registered, first request the cycle after reset release).
  - BUSY: hold pf_mc_en=1 and a stable address until mc_pf_ack. On ack, push {fetch_addr, mc_pf_data} to the tail and set fetch_addr+=ADDR_STEP (mod 2^ADDR_W). Next state: IDLE (a new request is issued in the cycle after the ack).
  - DRAIN: keep pf_mc_en=1 and the old address until mc_pf_ack. Discard the data, go to IDLE; fetch_addr already holds the redirect target.
- At most one outstanding request. No request is issued while count==DEPTH.
- Serve (combinational):
  - pf_if_valid = if_pf_req & !empty & head_addr==if_pf_addr.
  - pf_if_instruc = head data, or 0 when empty.
  - Pop when pf_if_valid & !ex_if_stall.
- Miss/redirect: expected = head_addr if not empty, else fetch_addr. If if_pf_req & if_pf_addr!=expected:
  - next cycle the queue is empty and fetch_addr=if_pf_addr;
  - if BUSY, go to DRAIN; otherwise go to IDLE.
  - Evaluated regardless of ex_if_stall.
- Empty queue with if_pf_addr==fetch_addr: not a miss; wait. The ack writes the queue, and pf_if_valid rises the cycle after the ack (hit latency 1 cycle from ack).
- Simultaneous push and pop: count unchanged; a full queue may pop and push in the same cycle.
- Redirect and ack in the same cycle in BUSY: the ack data is discarded, the flush wins, next state IDLE (no DRAIN needed).
- A reset asserted mid-request abandons the outstanding read. The memory controller is reset by the same signal.

Optional Feature:
- Macro PF_STATS_EN defined: adds outputs pf_hit_count[15:0] and pf_miss_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - pf_hit_count increments on each pop.
  - pf_miss_count increments on each redirect.
- Macro undefined: the ports and counters do not exist; no other behaviour changes.

Test Plan:
- Release reset, memory returns data = address after a 3-cycle ack, if_pf_req=0 -> requests to 0,2,4,6 issued in order, then pf_mc_en stays 0 with count=4.
- Fetch requests PC 0,2,4,6 each cycle with ex_if_stall=0 after the queue fills -> pf_if_valid=1 every cycle, instructions 0,2,4,6, prefetch continues from 8.
- ex_if_stall=1 for 3 cycles with head at PC 4 -> pf_if_valid=1 and instruc=4 held, no pop, count unchanged.
- Redirect to PC 0x100 while a request to 8 is BUSY -> the ack for 8 is discarded (DRAIN), the next request is 0x100, and the first valid is instruc 0x100.
- fetch_addr at 0x3FFFE, sequential fetch -> the next request is address 0, no error.
- PF_STATS_EN build: 5 hits and 2 redirects -> pf_hit_count=5, pf_miss_count=2; forcing 70000 hits -> pf_hit_count saturates at 0xFFFF.
